// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry controller bus: scanner strobe with its row/col pattern in, accepted digits,
// strobes and the two-digit multiplexed display drive out.
interface keypad_entry_ctrl_if;
  logic       key_valid;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       key_stb;
  logic       key_err;
  logic [1:0] anode_n;
  logic [3:0] disp_digit;

  modport master (
    output key_valid, rows, cols,
    input  digit_new, digit_old, key_stb, key_err, anode_n, disp_digit
  );

  modport slave (
    input  key_valid, rows, cols,
    output digit_new, digit_old, key_stb, key_err, anode_n, disp_digit
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: decodes scanner strobes into a two-deep digit history and
// multiplexes both digits onto a two-anode display. Optional macro KEY_CLEAR_EN makes code C clear.
module keypad_entry_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  keypad_entry_ctrl_if.slave kif
);

  localparam int MAX_N = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [1:0] BLANK_A  = 2'd0;
  localparam logic [1:0] SHOW_NEW = 2'd1;
  localparam logic [1:0] BLANK_B  = 2'd2;
  localparam logic [1:0] SHOW_OLD = 2'd3;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;  4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;  4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;  4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;  4'hD: key_code = 4'h0;  4'hE: key_code = 4'hF;  default: key_code = 4'hD;
    endcase
  endfunction

  logic       vld_p0;
  logic       row_ok, col_ok;
  logic [1:0] row_idx, col_idx;
  logic [3:0] code_p0;
  logic       hit_p0, bad_p0, clr_p0;

  // Stage p0: combinational decode of the strobed row/col pattern
  always_comb begin
    vld_p0  = kif.key_valid;
    row_ok  = 1'b1;
    row_idx = 2'd0;
    case (kif.rows)
      4'b1000: row_idx = 2'd0;
      4'b0100: row_idx = 2'd1;
      4'b0010: row_idx = 2'd2;
      4'b0001: row_idx = 2'd3;
      default: row_ok  = 1'b0;
    endcase
    col_ok  = 1'b1;
    col_idx = 2'd0;
    case (kif.cols)
      4'b0111: col_idx = 2'd0;
      4'b1011: col_idx = 2'd1;
      4'b1101: col_idx = 2'd2;
      4'b1110: col_idx = 2'd3;
      default: col_ok  = 1'b0;
    endcase
    code_p0 = key_code(row_idx, col_idx);
    hit_p0  = vld_p0 && row_ok && col_ok;
    bad_p0  = vld_p0 && !(row_ok && col_ok);
`ifdef KEY_CLEAR_EN
    clr_p0  = hit_p0 && (code_p0 == 4'hC);
`else
    clr_p0  = 1'b0;
`endif
  end

  // Stage p1: digit history and one-cycle result strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      kif.digit_new <= 4'h0;
      kif.digit_old <= 4'h0;
      kif.key_stb   <= 1'b0;
      kif.key_err   <= 1'b0;
    end else begin
      kif.key_stb <= hit_p0;
      kif.key_err <= bad_p0;
      if (clr_p0) begin
        kif.digit_new <= 4'h0;
        kif.digit_old <= 4'h0;
      end else if (hit_p0) begin
        kif.digit_old <= kif.digit_new;
        kif.digit_new <= code_p0;
      end
    end
  end

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_last;

  always_comb begin
    cnt_last   = ((state == SHOW_NEW) || (state == SHOW_OLD)) ? SHOW_LAST : BLANK_LAST;
    state_next = BLANK_B;
    case (state)
      BLANK_B:  state_next = SHOW_NEW;
      SHOW_NEW: state_next = BLANK_A;
      BLANK_A:  state_next = SHOW_OLD;
      default:  state_next = BLANK_B;
    endcase
  end

  // Display scheduler runs free of key traffic; only reset touches it
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BLANK_B;
      cnt   <= '0;
    end else if (cnt == cnt_last) begin
      state <= state_next;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    kif.anode_n    = 2'b11;
    kif.disp_digit = 4'h0;
    case (state)
      SHOW_NEW: begin kif.anode_n = 2'b10; kif.disp_digit = kif.digit_new; end
      SHOW_OLD: begin kif.anode_n = 2'b01; kif.disp_digit = kif.digit_old; end
      default:  ;
    endcase
  end

endmodule
